// File: rtl/pd_pkg.sv
// pd_pkg: shared definitions for the packet-decoder SHA-256 block padder.
//   SHA_BLK_W / SHA_LEN_W : SHA-256 block width and length-field width.
//   pd_pad_state_t        : padder FSM states.
//   pd_num_blocks         : padded block count for a given message bit count.
//   pd_idx_w              : width of the block index output (minimum 1).
//   pd_byte_rev           : byte-reverse the low nbytes bytes of a word.
package pd_pkg;

  localparam int unsigned SHA_BLK_W = 512;
  localparam int unsigned SHA_LEN_W = 64;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    EMIT
  } pd_pad_state_t;

  // Message bits plus the '1' pad bit plus the 64-bit length, rounded up.
  function automatic int unsigned pd_num_blocks(input int unsigned msg_bits);
    return (msg_bits + SHA_LEN_W + 1 + SHA_BLK_W - 1) / SHA_BLK_W;
  endfunction

  function automatic int unsigned pd_idx_w(input int unsigned msg_bits);
    int unsigned nb;
    nb = pd_num_blocks(msg_bits);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  function automatic logic [63:0] pd_byte_rev(input logic [63:0] w,
                                             input int unsigned nbytes);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbytes) begin
        r[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pd_pad_word_gen.sv
// pd_pad_word_gen: combinational generator of SHA-256 padding words.
//   wcnt     : position in the padded word stream (0..TOTAL_WORDS-1).
//   pad_word : word to store at that position when it is not message data:
//              MSB-set word right after the message, the big-endian 64-bit
//              message bit length in the stream's last 64 bits, else zero.
module pd_pad_word_gen
  import pd_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MSG_WORDS = 20,
  parameter int unsigned CNT_W     = 5
) (
  input  logic [CNT_W-1:0]  wcnt,
  output logic [WORD_W-1:0] pad_word
);

  localparam int unsigned WPB         = SHA_BLK_W / WORD_W;
  localparam int unsigned MSG_BITS    = MSG_WORDS * WORD_W;
  localparam int unsigned TOTAL_WORDS = pd_num_blocks(MSG_BITS) * WPB;
  localparam int unsigned LEN_WORDS   = SHA_LEN_W / WORD_W;
  localparam int unsigned LEN_BASE    = TOTAL_WORDS - LEN_WORDS;
  localparam logic [SHA_LEN_W-1:0] MSG_LEN = SHA_LEN_W'(MSG_BITS);

  logic [SHA_LEN_W-1:0] len_shifted;

  always_comb begin
    pad_word    = '0;
    len_shifted = '0;
    if (wcnt == CNT_W'(MSG_WORDS)) begin
      pad_word[WORD_W-1] = 1'b1;
    end else begin
      // Length words: the first one carries the most significant part.
      for (int unsigned i = 0; i < LEN_WORDS; i++) begin
        if (wcnt == CNT_W'(LEN_BASE + i)) begin
          len_shifted = MSG_LEN >> ((LEN_WORDS - 1 - i) * WORD_W);
          pad_word    = len_shifted[WORD_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pd_block_padder.sv
// pd_block_padder: streaming SHA-256 message formatter.
// Accepts MSG_WORDS words of WORD_W bits, assembles 512-bit blocks and
// appends the SHA-256 padding ('1' bit, zero fill, 64-bit bit length).
//   clk, n_rst : clock (rising edge), asynchronous active-low reset.
//   clear      : synchronous abort back to the start of a message.
//   in_valid / in_data / in_ready : message word input handshake.
//   blk_valid / blk_data / blk_idx / blk_last / blk_ready : block output
//               handshake; word 0 of a block sits in blk_data[511 -: WORD_W].
//   busy       : message partially accepted or blocks still pending.
// Build option: define PD_BYTE_SWAP_EN to byte-reverse each accepted message
// word before storage (pad and length words are never swapped).
module pd_block_padder
  import pd_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MSG_WORDS = 20
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  clear,
  input  logic                                  in_valid,
  input  logic [WORD_W-1:0]                     in_data,
  output logic                                  in_ready,
  output logic                                  blk_valid,
  output logic [SHA_BLK_W-1:0]                  blk_data,
  output logic [pd_idx_w(MSG_WORDS*WORD_W)-1:0] blk_idx,
  output logic                                  blk_last,
  input  logic                                  blk_ready,
  output logic                                  busy
);

  localparam int unsigned WPB         = SHA_BLK_W / WORD_W;
  localparam int unsigned SLOT_W      = $clog2(WPB);
  localparam int unsigned NUM_BLOCKS  = pd_num_blocks(MSG_WORDS * WORD_W);
  localparam int unsigned TOTAL_WORDS = NUM_BLOCKS * WPB;
  localparam int unsigned CNT_W       = $clog2(TOTAL_WORDS);
  localparam int unsigned IDX_W       = pd_idx_w(MSG_WORDS * WORD_W);

  pd_pad_state_t state_q, state_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d;
  logic [SLOT_W-1:0]    slot;
  logic                 last_slot;
  logic                 msg_last;
  logic                 msg_left;
  logic                 stream_end;
  logic                 wr_en;
  logic [WORD_W-1:0]    wr_word;
  logic [WORD_W-1:0]    msg_word;
  logic [WORD_W-1:0]    pad_word;
  logic [SHA_BLK_W-1:0] data_d;

  pd_pad_word_gen #(
    .WORD_W    (WORD_W),
    .MSG_WORDS (MSG_WORDS),
    .CNT_W     (CNT_W)
  ) u_pad_gen (
    .wcnt     (wcnt_q),
    .pad_word (pad_word)
  );

`ifdef PD_BYTE_SWAP_EN
  logic [63:0] rev_word;
  always_comb begin
    rev_word = pd_byte_rev(64'(in_data), WORD_W / 8);
    msg_word = rev_word[WORD_W-1:0];
  end
`else
  assign msg_word = in_data;
`endif

  assign slot       = wcnt_q[SLOT_W-1:0];
  assign last_slot  = &slot;
  assign msg_last   = (wcnt_q == CNT_W'(MSG_WORDS - 1));
  assign msg_left   = (wcnt_q < CNT_W'(MSG_WORDS));
  assign stream_end = (wcnt_q == CNT_W'(TOTAL_WORDS - 1));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wr_en     = 1'b0;
    wr_word   = msg_word;
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_word = pad_word;
      end
      EMIT: begin
        blk_valid = 1'b1;
        // wcnt wraps to 0 after the final slot, so a finished message also
        // lands in FILL through the msg_left test.
        if (blk_ready) begin
          state_d = msg_left ? FILL : PAD;
        end
      end
      default: state_d = FILL;
    endcase

    if (wr_en) begin
      wcnt_d = stream_end ? '0 : wcnt_q + 1'b1;
      if (last_slot) begin
        state_d = EMIT;
      end else if ((state_q == FILL) && msg_last) begin
        state_d = PAD;
      end
    end

    if (clear) begin
      state_d = FILL;
      wcnt_d  = '0;
      wr_en   = 1'b0;
    end
  end

  always_comb begin
    data_d = blk_data;
    if (wr_en) begin
      for (int unsigned s = 0; s < WPB; s++) begin
        if (slot == SLOT_W'(s)) begin
          data_d[SHA_BLK_W-1-s*WORD_W -: WORD_W] = wr_word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= FILL;
      wcnt_q   <= '0;
      blk_data <= '0;
      blk_idx  <= '0;
      blk_last <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      blk_data <= data_d;
      if (wr_en && last_slot) begin
        blk_idx  <= IDX_W'(wcnt_q >> SLOT_W);
        blk_last <= stream_end;
      end
    end
  end

  assign busy = (wcnt_q != '0) || (state_q != FILL);

endmodule

// File: tb/tb_pd_block_padder.sv
`timescale 1ns/1ps
// Bench for pd_block_padder: four instances (MSG_WORDS 20, 13, 14, 16) are
// checked every cycle against a stream-level model of the padded message.
module tb_pd_block_padder;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;
  logic m_blk_ready = 1'b0;
  logic chk_rst = 1'b0;
  logic tmo = 1'b0;

  logic         in_v  [NDUT];
  logic [31:0]  in_d  [NDUT];
  logic         o_rdy [NDUT];
  logic         o_val [NDUT];
  logic         o_last[NDUT];
  logic         o_busy[NDUT];
  logic         o_idx [NDUT];
  logic [511:0] o_data[NDUT];
  logic         b_rdy [NDUT];

  logic [31:0]  base     [NDUT];
  int unsigned  sent     [NDUT];
  int unsigned  tgt      [NDUT];
  int unsigned  eidx     [NDUT];
  int unsigned  acc      [NDUT];
  int unsigned  mark     [NDUT];
  int unsigned  done_cnt [NDUT];
  bit           prev_v   [NDUT];
  bit           hs_prev  [NDUT];
  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [511:0] e_blk;
  int unsigned  e_acc;

  assign b_rdy[0] = m_blk_ready;
  assign b_rdy[1] = 1'b1;
  assign b_rdy[2] = 1'b1;
  assign b_rdy[3] = 1'b1;

  always #5 clk = ~clk;

  pd_block_padder #(.WORD_W(32), .MSG_WORDS(20)) u_dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_v[0]), .in_data(in_d[0]),
    .in_ready(o_rdy[0]), .blk_valid(o_val[0]), .blk_data(o_data[0]), .blk_idx(o_idx[0]),
    .blk_last(o_last[0]), .blk_ready(b_rdy[0]), .busy(o_busy[0]));
  pd_block_padder #(.WORD_W(32), .MSG_WORDS(13)) u_m13 (
    .clk(clk), .n_rst(n_rst), .clear(1'b0), .in_valid(in_v[1]), .in_data(in_d[1]),
    .in_ready(o_rdy[1]), .blk_valid(o_val[1]), .blk_data(o_data[1]), .blk_idx(o_idx[1]),
    .blk_last(o_last[1]), .blk_ready(b_rdy[1]), .busy(o_busy[1]));
  pd_block_padder #(.WORD_W(32), .MSG_WORDS(14)) u_m14 (
    .clk(clk), .n_rst(n_rst), .clear(1'b0), .in_valid(in_v[2]), .in_data(in_d[2]),
    .in_ready(o_rdy[2]), .blk_valid(o_val[2]), .blk_data(o_data[2]), .blk_idx(o_idx[2]),
    .blk_last(o_last[2]), .blk_ready(b_rdy[2]), .busy(o_busy[2]));
  pd_block_padder #(.WORD_W(32), .MSG_WORDS(16)) u_m16 (
    .clk(clk), .n_rst(n_rst), .clear(1'b0), .in_valid(in_v[3]), .in_data(in_d[3]),
    .in_ready(o_rdy[3]), .blk_valid(o_val[3]), .blk_data(o_data[3]), .blk_idx(o_idx[3]),
    .blk_last(o_last[3]), .blk_ready(b_rdy[3]), .busy(o_busy[3]));

  // ---------------- model ----------------
  function automatic int unsigned mw_of(input int k);
    case (k)
      0:       return 20;
      1:       return 13;
      2:       return 14;
      default: return 16;
    endcase
  endfunction

  function automatic int unsigned nblk(input int unsigned mw);
    return (mw * 32 + 65 + 511) / 512;
  endfunction

  // Word as the block must hold it (the source sends base+i+1).
  function automatic logic [31:0] stored_word(input logic [31:0] b, input int unsigned i);
    logic [31:0] w;
    w = b + 32'(i) + 32'd1;
`ifdef PD_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic logic [511:0] exp_block(input int unsigned mw, input logic [31:0] b,
                                             input int unsigned bi);
    logic [511:0] r;
    int unsigned total, w;
    total = nblk(mw) * 16;
    r = '0;
    for (int unsigned s = 0; s < 16; s++) begin
      w = bi * 16 + s;
      if (w < mw)              r[511-32*s -: 32] = stored_word(b, w);
      else if (w == mw)        r[511-32*s -: 32] = 32'h8000_0000;
      else if (w == total - 1) r[511-32*s -: 32] = 32'(mw * 32);
    end
    return r;
  endfunction

  function automatic logic [31:0] slot_of(input logic [511:0] b, input int unsigned s);
    return b[511-32*s -: 32];
  endfunction

  task automatic chk(input string name, input int k, input logic [511:0] act,
                     input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (tmo) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout cyc=%0d got=expired want=event", cyc);
    end
    if (chk_rst) begin
      chk("rst_valid", 0, o_val[0], 0);
      chk("rst_busy", 0, o_busy[0], 0);
      chk("rst_in_ready", 0, o_rdy[0], 1);
      chk("rst_data", 0, o_data[0], 0);
      chk("rst_idx", 0, o_idx[0], 0);
      chk("rst_last", 0, o_last[0], 0);
    end
    for (int k = 0; k < NDUT; k++) begin
      if (!n_rst || (k == 0 && clear)) begin
        eidx[k] = 0; acc[k] = 0; prev_v[k] = 0; hs_prev[k] = 0;
        continue;
      end
      if (hs_prev[k]) begin
        chk("in_ready_after_hs", k, o_rdy[k], (eidx[k] * 16 < mw_of(k)) ? 1 : 0);
        chk("busy_after_hs", k, o_busy[k], (eidx[k] != 0) ? 1 : 0);
      end
      hs_prev[k] = 0;
      if (in_v[k] && o_rdy[k]) begin
        if (acc[k] == 0 && eidx[k] == 0) mark[k] = cyc;
        acc[k]++;
      end
      if (o_val[k]) begin
        e_blk = exp_block(mw_of(k), base[k], eidx[k]);
        chk("blk_data", k, o_data[k], e_blk);
        chk("blk_idx", k, o_idx[k], eidx[k][0]);
        chk("blk_last", k, o_last[k], (eidx[k] == nblk(mw_of(k)) - 1) ? 1 : 0);
        chk("in_ready_in_emit", k, o_rdy[k], 0);
        chk("busy_in_emit", k, o_busy[k], 1);
        if (!prev_v[k]) begin
          e_acc = ((eidx[k] + 1) * 16 < mw_of(k)) ? (eidx[k] + 1) * 16 : mw_of(k);
          chk("words_consumed", k, acc[k], e_acc);
          chk("block_latency", k, cyc - mark[k], 16);
          if (base[k] == 0) begin
            case (k)
              0: if (eidx[k] == 1) begin
                   chk("pin20_pad", k, slot_of(o_data[k], 4), 32'h8000_0000);
                   chk("pin20_lenhi", k, slot_of(o_data[k], 14), 32'h0);
                   chk("pin20_len", k, slot_of(o_data[k], 15), 32'h0000_0280);
                 end else begin
`ifdef PD_BYTE_SWAP_EN
                   chk("pin20_w0", k, slot_of(o_data[k], 0), 32'h0100_0000);
`else
                   chk("pin20_w0", k, slot_of(o_data[k], 0), 32'h0000_0001);
`endif
                 end
              1: begin
                   chk("pin13_pad", k, slot_of(o_data[k], 13), 32'h8000_0000);
                   chk("pin13_lenhi", k, slot_of(o_data[k], 14), 32'h0);
                   chk("pin13_len", k, slot_of(o_data[k], 15), 32'h0000_01A0);
                 end
              2: if (eidx[k] == 0) begin
                   chk("pin14_pad", k, slot_of(o_data[k], 14), 32'h8000_0000);
                   chk("pin14_s15", k, slot_of(o_data[k], 15), 32'h0);
                 end else begin
                   chk("pin14_s0", k, slot_of(o_data[k], 0), 32'h0);
                   chk("pin14_len", k, slot_of(o_data[k], 15), 32'h0000_01C0);
                 end
              default: if (eidx[k] == 1) begin
                   chk("pin16_pad", k, slot_of(o_data[k], 0), 32'h8000_0000);
                   chk("pin16_len", k, slot_of(o_data[k], 15), 32'h0000_0200);
                 end
            endcase
          end
        end
        if (b_rdy[k]) begin
          hs_prev[k] = 1;
          mark[k] = cyc + 1;
          eidx[k]++;
          if (eidx[k] == nblk(mw_of(k))) begin
            eidx[k] = 0;
            acc[k] = 0;
            done_cnt[k]++;
          end
        end
      end
      prev_v[k] = o_val[k] && !b_rdy[k];
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    logic r [NDUT];
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) r[k] = o_rdy[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      if (in_v[k] && r[k]) begin
        sent[k]++;
        if (sent[k] >= tgt[k]) in_v[k] = 1'b0;
        else in_d[k] = base[k] + 32'(sent[k]) + 32'd1;
      end
    end
  endtask

  task automatic start(input int k, input int unsigned n);
    sent[k] = 0;
    tgt[k]  = n;
    in_d[k] = base[k] + 32'd1;
    in_v[k] = 1'b1;
  endtask

  task automatic signal_tmo();
    tmo = 1'b1;
    @(negedge clk);
    #1 tmo = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int k, input int unsigned target);
    int n = 0;
    while (done_cnt[k] < target && n < 400) begin step(); n++; end
    if (done_cnt[k] < target) signal_tmo();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_val[0] && n < 100) begin step(); n++; end
    if (!o_val[0]) signal_tmo();
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      in_v[k] = 1'b0; in_d[k] = '0; base[k] = '0; sent[k] = 0; tgt[k] = 0;
      eidx[k] = 0; acc[k] = 0; mark[k] = 0; done_cnt[k] = 0;
      prev_v[k] = 0; hs_prev[k] = 0;
    end
    chk_rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 chk_rst = 1'b0;

    // Test 1: header message plus the 13/14/16-word boundary cases.
    m_blk_ready = 1'b1;
    start(0, 20); start(1, 13); start(2, 14); start(3, 16);
    begin
      int n = 0;
      while ((done_cnt[0] < 1 || done_cnt[1] < 1 || done_cnt[2] < 1 || done_cnt[3] < 1)
             && n < 400) begin
        step(); n++;
      end
      if (done_cnt[0] < 1 || done_cnt[1] < 1 || done_cnt[2] < 1 || done_cnt[3] < 1)
        signal_tmo();
    end
    repeat (3) step();

    // Test 2: hold blk_ready low for 10 cycles in EMIT.
    base[0] = 32'h0000_0100;
    m_blk_ready = 1'b0;
    start(0, 20);
    wait_valid();
    repeat (10) step();
    m_blk_ready = 1'b1;
    run_until_done(0, 2);
    repeat (3) step();

    // Test 3: abort after 7 words, then the test-1 message again.
    base[0] = 32'hA5A5_0000;
    start(0, 7);
    begin
      int n = 0;
      while (sent[0] < 7 && n < 50) begin step(); n++; end
      if (sent[0] < 7) signal_tmo();
    end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    base[0] = 32'h0;
    start(0, 20);
    run_until_done(0, 3);
    repeat (3) step();

    // Test 4: reset while a block waits in EMIT, then a clean message.
    base[0] = 32'h0000_0200;
    m_blk_ready = 1'b0;
    start(0, 20);
    wait_valid();
    #1;
    n_rst = 1'b0;
    chk_rst = 1'b1;
    in_v[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 chk_rst = 1'b0;
    base[0] = 32'h0;
    m_blk_ready = 1'b1;
    start(0, 20);
    run_until_done(0, 4);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_block_padder.md
# pd_block_padder

Streaming SHA-256 message formatter for the packet decoder. Accepts a fixed-length message one word per handshake, assembles 512-bit blocks, and appends the standard SHA-256 padding itself: the `1` bit, zero fill and the 64-bit bit-length. It presents each block to the hash core over a valid/ready interface. It sits between the packet-decoder chunk registers and the SHA-256 core, and supports any word-aligned message length, including the 640-bit block header.

## Interface
- `WORD_W`, 32, input word width; must be 32 or 64.
- `MSG_WORDS`, 20, message length in words; message bits = `MSG_WORDS*WORD_W` and must be < 2^16.
- `clk` input 1: single clock, rising edge.
- `n_rst` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous abort; returns the block to its start state.
- `in_valid` input 1: `in_data` holds a message word.
- `in_data` input `WORD_W`: message word, first word is most significant.
- `in_ready` output 1: padder accepts a word this cycle.
- `blk_valid` output 1: `blk_data` holds a complete padded block.
- `blk_data` output 512: the block; word 0 is in bits [511:512-`WORD_W`].
- `blk_idx` output `max(1,$clog2(NUM_BLOCKS))`: index of the block within the message.
- `blk_last` output 1: final block of the message.
- `blk_ready` input 1: hash core accepts the block.
- `busy` output 1: a message is partially accepted, or blocks are still pending.

## Operation
- Derived constants:
  - `WPB` = 512/`WORD_W`.
  - `NUM_BLOCKS` = ceil((msg bits + 65)/512).
  - `TOTAL_WORDS` = `NUM_BLOCKS*WPB`.
- A word counter `wcnt` (0..`TOTAL_WORDS`-1) indexes the padded stream. The slot within the block is `wcnt mod WPB`.
- Slot contents by `wcnt`:
  - `wcnt` < `MSG_WORDS`: message word.
  - `wcnt` == `MSG_WORDS`: pad word, MSB set, all other bits zero.
  - Last 64 bits of the stream: the message bit-length, big-endian.
  - Everything else: zero.
- FSM, reset state FILL:
  - FILL: `in_ready`=1. Each `in_valid&&in_ready` writes the word into the current slot and increments `wcnt`. After writing a block's final slot, go to EMIT. After writing message word `MSG_WORDS`-1 into a non-final slot, go to PAD.
  - PAD: `in_ready`=0. Writes one generated pad word per cycle. After writing a block's final slot, go to EMIT.
  - EMIT: `blk_valid`=1. `blk_data`, `blk_idx` and `blk_last` are held stable until `blk_ready`. On handshake the next state depends on what remains:
    - message words remain: FILL;
    - pad words remain: PAD;
    - otherwise: FILL with `wcnt`=0, ready for the next message.
- When `MSG_WORDS` is a multiple of `WPB`, the padding occupies a whole extra block.
- When the `1` pad word fits but the length does not, the length goes in the next block and that block is emitted separately.
- `clear` has priority over every other event. On the next edge: state FILL, `wcnt`=0, `blk_valid`=0, buffer contents don't-care. A block in EMIT is dropped even if `blk_ready` is high in the same cycle.
- `busy` = (`wcnt`≠0) || (state≠FILL).
- Words presented while `in_ready`=0 are not consumed; the source holds them.

## Timing
- Reset values: state FILL, `wcnt`=0, `blk_valid`=0, `blk_data`=0, `blk_idx`=0, `blk_last`=0, `busy`=0. `in_ready`=1, since it is decoded from state.
- Reset mid-operation discards all progress; there is no partial-block output.
- Throughput: one word per cycle in FILL and in PAD.
- `blk_valid` rises on the edge that writes a block's final slot, i.e. one cycle after the final handshake or pad write.
- `blk_data` is registered; there is no combinational path from `in_data` to `blk_data`.
- The EMIT→FILL/PAD transition happens on the handshake edge, so there is one dead cycle per block minimum.
- 640-bit header at `WORD_W`=32 with no backpressure:
  - block 0 valid at cycle 16 after the first accepted word;
  - block 1 takes 4 FILL cycles plus 12 PAD cycles after the block 0 handshake.

## Configuration
- `PD_BYTE_SWAP_EN`:
  - Defined: each accepted message word is byte-reversed before storage (little-endian header fields to SHA big-endian). Generated pad and length words are never swapped.
  - Undefined: words are stored unchanged.

## Structure
- Shared package `pd_pkg` holds:
  - `SHA_BLK_W`=512 and `SHA_LEN_W`=64;
  - the state enum `pd_pad_state_t` {FILL, PAD, EMIT};
  - a byte-reverse function used under the macro.
- One sub-module, `pd_pad_word_gen`: combinational, maps `wcnt` to the generated pad word, parametrised by `WORD_W` and `MSG_WORDS`.

## Test plan
- Default params, words 0x00000001..0x00000014, `blk_ready`=1 → block 0 = words 1..16 with idx0, last0. Block 1 = {0x11,0x12,0x13,0x14,0x80000000, 9×0, 0x00000000, 0x00000280} with idx1, last1.
- `MSG_WORDS`=13 → one block, slot13=0x80000000, slot14=0, slot15=0x000001A0, `blk_last`=1. `MSG_WORDS`=14 → two blocks: block 0 slot14=0x80000000, slot15=0; block 1 all zero except slot15=0x000001C0.
- `MSG_WORDS`=16 → block 0 = message, block 1 = {0x80000000, 14×0, 0x00000200}.
- Hold `blk_ready`=0 for 10 cycles in EMIT → `blk_valid` and `blk_data` stable, `in_ready`=0, no word consumed. Release → next word accepted the cycle after the handshake.
- Assert `clear` after 7 words, then send a full message → outputs identical to test 1. Assert `n_rst` low during EMIT → `blk_valid`=0 immediately, `busy`=0.
- `PD_BYTE_SWAP_EN` defined, first word 0x01020304 → `blk_data`[511:480]=0x04030201, length word still 0x00000280.
